// File: rtl/if_id_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_reg_pkg
// Description : Shared control encodings, bubble word and skid-state codes
//               for the IF/ID stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_stage_reg_pkg;

    localparam logic        c_rst_enable    = 1'b1;
    localparam logic        c_clear_enable  = 1'b1;
    localparam logic        c_clear_disable = 1'b0;
    localparam logic        c_stall_enable  = 1'b1;
    localparam logic        c_stall_disable = 1'b0;

    localparam logic [31:0] c_nop_inst      = 32'h0000_0000;

    // Skid buffer occupancy states
    localparam int          c_sk_w          = 1;
    localparam logic [c_sk_w-1:0] c_sk_empty = 1'b0;
    localparam logic [c_sk_w-1:0] c_sk_full  = 1'b1;

endpackage : if_id_stage_reg_pkg
`default_nettype wire

// File: rtl/if_id_stage_reg_inst_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : inst_skid_buf
// Description : One-entry {pc, inst} holding buffer with load, unload and
//               flush controls; reports occupancy on o_full.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_skid_buf
    import if_id_stage_reg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_inst,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_inst
);

    logic [c_sk_w-1:0] r_state;
    logic [c_sk_w-1:0] w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_inst;
    logic              w_capture;

    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_state <= c_sk_empty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            c_sk_empty: begin
                if (!i_flush && i_load) begin
                    w_state_next = c_sk_full;
                    w_capture    = 1'b1;
                end
            end
            c_sk_full: begin
                if (i_flush || i_unload) begin
                    w_state_next = c_sk_empty;
                end
            end
            default: w_state_next = c_sk_empty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_pc   <= '0;
            r_inst <= '0;
        end else if (w_capture) begin
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end
    end

    assign o_full = (r_state == c_sk_full);
    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule : inst_skid_buf
`default_nettype wire

// File: rtl/if_id_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_reg
// Description : IF/ID pipeline register with flush bubble, stall hold,
//               one-entry skid buffer and saturating flush counter.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage_reg
    import if_id_stage_reg_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(c_nop_inst),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              stall,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_inst,
    input  logic              if_valid,
    output logic              if_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              w_skid_full;
    logic [ADDR_W-1:0] w_skid_pc;
    logic [DATA_W-1:0] w_skid_inst;
    logic              w_accept;
    logic              w_load;
    logic              w_unload;
    logic              w_clear;
    logic              w_stall;

    logic [ADDR_W-1:0] r_id_pc;
    logic [DATA_W-1:0] r_id_inst;
    logic              r_id_valid;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_clear  = (clear == c_clear_enable);
    assign w_stall  = (stall == c_stall_enable);
    assign if_ready = (rst != c_rst_enable) & ~w_skid_full;
    assign w_accept = if_valid & if_ready;

    // A stalled decode parks the accepted word; an unstalled one drains the skid first.
    assign w_load   = ~w_clear & w_stall & w_accept;
    assign w_unload = ~w_clear & ~w_stall;

    inst_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_unload (w_unload),
        .i_flush  (w_clear),
        .i_pc     (if_pc),
        .i_inst   (if_inst),
        .o_full   (w_skid_full),
        .o_pc     (w_skid_pc),
        .o_inst   (w_skid_inst)
    );

    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_id_pc    <= '0;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else if (w_clear) begin
            r_id_pc    <= '0;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else if (w_stall) begin
            r_id_pc    <= r_id_pc;
            r_id_inst  <= r_id_inst;
            r_id_valid <= r_id_valid;
        end else if (w_skid_full) begin
            r_id_pc    <= w_skid_pc;
            r_id_inst  <= w_skid_inst;
            r_id_valid <= 1'b1;
        end else if (w_accept) begin
            r_id_pc    <= if_pc;
            r_id_inst  <= if_inst;
            r_id_valid <= 1'b1;
        end else begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end
    end

    // Counts clear cycles and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_flush_cnt <= '0;
        end else if (w_clear && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign id_pc     = r_id_pc;
    assign id_inst   = r_id_inst;
    assign id_valid  = r_id_valid;
    assign flush_cnt = r_flush_cnt;

endmodule : if_id_stage_reg
`default_nettype wire

// File: tb/tb_if_id_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage_reg
// Description : Self-checking bench for if_id_stage_reg against a queue-based
//               behavioural model; wide and 2-bit counter instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage_reg;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        stall;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    logic        if_ready,   if_ready_s;
    logic [31:0] id_pc,      id_pc_s;
    logic [31:0] id_inst,    id_inst_s;
    logic        id_valid,   id_valid_s;
    logic [15:0] flush_cnt;
    logic [1:0]  flush_cnt_s;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [63:0] m_skid[$];
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_valid;
    int          m_flushes;
    bit          m_init = 1'b0;

    if_id_stage_reg #(.ADDR_W(32), .DATA_W(32), .NOP_INST(32'h0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .stall(stall),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_ready(if_ready),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .flush_cnt(flush_cnt)
    );

    if_id_stage_reg #(.ADDR_W(32), .DATA_W(32), .NOP_INST(32'h0), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .stall(stall),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_ready(if_ready_s),
        .id_pc(id_pc_s), .id_inst(id_inst_s), .id_valid(id_valid_s), .flush_cnt(flush_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_pc = '0; m_inst = '0; m_valid = 1'b0;
            m_skid.delete();
            m_flushes = 0;
            m_init = 1'b1;
        end else if (clear) begin
            m_pc = '0; m_inst = '0; m_valid = 1'b0;
            m_skid.delete();
            m_flushes++;
        end else if (stall) begin
            if (m_skid.size() == 0 && if_valid) m_skid.push_back({if_pc, if_inst});
        end else if (m_skid.size() != 0) begin
            {m_pc, m_inst} = m_skid.pop_front();
            m_valid = 1'b1;
        end else if (if_valid) begin
            m_pc = if_pc; m_inst = if_inst; m_valid = 1'b1;
        end else begin
            m_inst = '0; m_valid = 1'b0;
        end
    endtask

    task automatic set_in(input logic r, input logic c, input logic s,
                          input logic v, input logic [31:0] pc, input logic [31:0] inst);
        rst = r; clear = c; stall = s; if_valid = v; if_pc = pc; if_inst = inst;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_init) begin
            chk("if_ready",    {63'd0, if_ready},   {63'd0, (!rst && m_skid.size() == 0)});
            chk("id_valid",    {63'd0, id_valid},   {63'd0, m_valid});
            chk("id_pc",       {32'd0, id_pc},      {32'd0, m_pc});
            chk("id_inst",     {32'd0, id_inst},    {32'd0, m_inst});
            chk("flush_cnt",   {48'd0, flush_cnt},  64'(m_flushes > 65535 ? 65535 : m_flushes));
            chk("s_if_ready",  {63'd0, if_ready_s}, {63'd0, (!rst && m_skid.size() == 0)});
            chk("s_id_valid",  {63'd0, id_valid_s}, {63'd0, m_valid});
            chk("s_id_pc",     {32'd0, id_pc_s},    {32'd0, m_pc});
            chk("s_id_inst",   {32'd0, id_inst_s},  {32'd0, m_inst});
            chk("s_flush_cnt", {62'd0, flush_cnt_s}, 64'(m_flushes > 3 ? 3 : m_flushes));
        end
    end

    initial begin
        set_in(1, 0, 0, 0, 32'h0, 32'h0);

        // Reset
        #1 chk("rst_ready", {63'd0, if_ready}, 64'd0);
        tick(); tick();
        chk("rst_valid", {63'd0, id_valid}, 64'd0);
        chk("rst_inst",  {32'd0, id_inst},  64'd0);
        chk("rst_cnt",   {48'd0, flush_cnt}, 64'd0);

        // Stream 0x0, 0x4, 0x8
        set_in(0, 0, 0, 1, 32'h0, 32'h1000_0013);
        #1 chk("ready_after_rst", {63'd0, if_ready}, 64'd1);
        tick();
        chk("stream_pc0", {32'd0, id_pc}, 64'h0);
        chk("stream_v0",  {63'd0, id_valid}, 64'd1);
        set_in(0, 0, 0, 1, 32'h4, 32'h1000_0014); tick();
        chk("stream_pc4", {32'd0, id_pc}, 64'h4);
        set_in(0, 0, 0, 1, 32'h8, 32'h1000_0015); tick();
        chk("stream_pc8", {32'd0, id_pc}, 64'h8);

        // Stall two cycles while 0xC arrives
        set_in(0, 0, 1, 1, 32'hC, 32'h1000_0016); tick();
        chk("stall_hold1", {32'd0, id_pc}, 64'h8);
        set_in(0, 0, 1, 1, 32'h10, 32'h1000_0017);
        #1 chk("stall_ready0", {63'd0, if_ready}, 64'd0);
        tick();
        chk("stall_hold2", {32'd0, id_pc}, 64'h8);
        set_in(0, 0, 0, 0, 32'h0, 32'h0); tick();
        chk("skid_out_pc",   {32'd0, id_pc},   64'hC);
        chk("skid_out_inst", {32'd0, id_inst}, 64'h1000_0016);

        // Flush with skid full
        set_in(0, 0, 0, 1, 32'h8, 32'h1000_0018); tick();
        set_in(0, 0, 1, 1, 32'h14, 32'h1000_0019); tick();
        set_in(0, 1, 0, 0, 32'h0, 32'h0); tick();
        chk("flush_valid", {63'd0, id_valid}, 64'd0);
        chk("flush_inst",  {32'd0, id_inst},  64'd0);
        chk("flush_cnt1",  {48'd0, flush_cnt}, 64'd1);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);
        #1 chk("flush_skid_empty", {63'd0, if_ready}, 64'd1);

        // Clear together with stall, then 0x40
        set_in(0, 1, 1, 1, 32'h30, 32'h1000_001A); tick();
        chk("clrstall_valid", {63'd0, id_valid}, 64'd0);
        set_in(0, 0, 0, 1, 32'h40, 32'h1000_001B); tick();
        chk("after_clr_pc", {32'd0, id_pc}, 64'h40);
        chk("after_clr_v",  {63'd0, id_valid}, 64'd1);

        // Counter saturation: 2 flushes so far, 5 more
        set_in(0, 1, 0, 0, 32'h0, 32'h0);
        repeat (5) tick();
        chk("cnt16_7", {48'd0, flush_cnt},   64'd7);
        chk("cnt2_sat", {62'd0, flush_cnt_s}, 64'd3);

        // Reset while stalled with skid full
        set_in(0, 0, 1, 1, 32'h50, 32'h1000_001C); tick();
        set_in(1, 0, 1, 0, 32'h0, 32'h0);
        #1 chk("rst_stall_ready", {63'd0, if_ready}, 64'd0);
        tick();
        chk("rst_stall_cnt", {48'd0, flush_cnt}, 64'd0);
        set_in(0, 0, 0, 0, 32'h0, 32'h0); tick();
        chk("skid_discarded", {63'd0, id_valid}, 64'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 100) == 0, ($urandom % 10) == 0, ($urandom % 3) == 0,
                   ($urandom % 10) < 7, {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_if_id_stage_reg
`default_nettype wire
